mem_stage_ctrl: RTL and testbench
=================================

// Module: mem_stage_ctrl
// PURPOSE
//  MEM-stage consumer of the EX/MEM pipeline register. Resolves the branch (PCSrc),
//  runs loads/stores on a multi-cycle data memory via a req/ready handshake, stalls
//  the upstream pipeline while an access is outstanding, and registers the MEM/WB outputs.
//  Sits between the EX/MEM latch outputs and the MEM/WB write-back path.
// PARAMETERS
//  B        32   data/address width
//  W        5    register-destination index width
//  TIMEOUT  16   max WAIT cycles before an access is aborted (>=1)
// PORTS
//  clk               in   1  clock, rising edge
//  reset             in   1  asynchronous, active-high reset
//  add_result_in     in   B  branch target from EX/MEM
//  alu_result_in     in   B  byte address / ALU result from EX/MEM
//  r_data2_in        in   B  store data from EX/MEM
//  mux_RegDst_in     in   W  destination register from EX/MEM
//  zero_in           in   1  ALU zero flag from EX/MEM
//  wb_RegWrite_in    in   1  WB control: register write
//  wb_MemtoReg_in    in   1  WB control: select memory data
//  m_Branch_in       in   1  MEM control: branch instruction
//  m_MemRead_in      in   1  MEM control: load
//  m_MemWrite_in     in   1  MEM control: store
//  mem_req           out  1  data-memory request (registered)
//  mem_we            out  1  1=write, 0=read; valid while mem_req=1
//  mem_addr          out  B  byte address, held while mem_req=1
//  mem_wdata         out  B  store data, held while mem_req=1
//  mem_rdata         in   B  load data, valid in the cycle mem_ready=1
//  mem_ready         in   1  access completes in this cycle
//  stall             out  1  freeze IF/ID/EX and the EX/MEM latch (combinational)
//  pc_src            out  1  take the branch (combinational)
//  branch_target     out  B  = add_result_in
//  read_data_out     out  B  MEM/WB: load data
//  alu_result_out    out  B  MEM/WB: ALU result
//  mux_RegDst_out    out  W  MEM/WB: destination register
//  wb_RegWrite_out   out  1  MEM/WB: register write
//  wb_MemtoReg_out   out  1  MEM/WB: select memory data
//  mem_error         out  1  sticky: timeout or misaligned access
// BEHAVIOUR
//  - Reset: state=IDLE, timeout count=0; all registered outputs, mem_req and mem_error = 0.
//  - pc_src = m_Branch_in & zero_in; branch_target = add_result_in. Both combinational, no stall.
//  - Access = MemRead|MemWrite. If both are set, the store wins and read_data_out=0.
//  - Misaligned access (alu_result_in[1:0]!=0) issues no request, sets mem_error, and
//    completes as a non-memory instruction with read_data_out=0.
//  - FSM:
//    * IDLE, no access: MEM/WB regs load the inputs at the edge (1-cycle latency); stall=0.
//    * IDLE, access: stall=1. Capture addr/wdata/we, then go to WAIT; mem_req=1 from the
//      next cycle.
//    * WAIT: stall=1, mem_req/we/addr/wdata held. Counter increments each cycle.
//      On mem_ready=1: at that edge the MEM/WB regs load the captured ctrl/addr, and
//      read_data_out=mem_rdata for a load (0 for a store). mem_req=0 and state=IDLE.
//      stall drops combinationally in the ready cycle, so upstream advances at the same edge.
//    * Counter reaches TIMEOUT without ready: abort. mem_req=0, mem_error=1,
//      completes with read_data_out=0 and wb_RegWrite_out=0. Returns to IDLE.
//  - While in WAIT (not completing): wb_RegWrite_out=0 and wb_MemtoReg_out=0 (bubble);
//    data outputs hold.
//  - mem_ready while in IDLE is ignored. A new access is never issued in the same cycle
//    as a completion.
//  - Reset mid-access drops mem_req immediately and discards the access.
//  - mem_error clears only on reset.
// TESTING
//  1 ALU op (RegWrite=1, no mem) alu=0x10, dst=5 -> next edge alu_result_out=0x10, dst=5, RegWrite=1, stall=0.
//  2 Load addr 0x40, ready after 3 WAIT cycles with rdata=0xDEADBEEF -> stall=1 for 4 cycles,
//    then read_data_out=0xDEADBEEF, MemtoReg=1; bubbles in between.
//  3 Store addr 0x44, wdata=0x1234, ready in the first WAIT cycle -> mem_we=1,
//    mem_addr=0x44 held, one req cycle, read_data_out=0.
//  4 Load with ready never asserted (TIMEOUT=16) -> abort after 16 WAIT cycles,
//    mem_error=1, wb_RegWrite_out=0, stall released.
//  5 Branch=1, zero=1, add=0x100 -> pc_src=1, branch_target=0x100 same cycle; zero=0 -> pc_src=0.
//  6 Reset asserted during WAIT -> mem_req, outputs and mem_error=0 asynchronously; next op runs normally.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// MEM stage: branch resolution, multi-cycle data-memory handshake with timeout,
// pipeline stall generation and the MEM/WB output register.
module mem_stage_ctrl #(
   parameter int B       = 32,
   parameter int W       = 5,
   parameter int TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [B-1:0] add_result_in,
   input  logic [B-1:0] alu_result_in,
   input  logic [B-1:0] r_data2_in,
   input  logic [W-1:0] mux_RegDst_in,
   input  logic         zero_in,
   input  logic         wb_RegWrite_in,
   input  logic         wb_MemtoReg_in,
   input  logic         m_Branch_in,
   input  logic         m_MemRead_in,
   input  logic         m_MemWrite_in,
   output logic         mem_req,
   output logic         mem_we,
   output logic [B-1:0] mem_addr,
   output logic [B-1:0] mem_wdata,
   input  logic [B-1:0] mem_rdata,
   input  logic         mem_ready,
   output logic         stall,
   output logic         pc_src,
   output logic [B-1:0] branch_target,
   output logic [B-1:0] read_data_out,
   output logic [B-1:0] alu_result_out,
   output logic [W-1:0] mux_RegDst_out,
   output logic         wb_RegWrite_out,
   output logic         wb_MemtoReg_out,
   output logic         mem_error
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t        state, next_state;
   logic [CW-1:0] cnt;
   logic [W-1:0]  cap_dst;
   logic          cap_regwrite, cap_memtoreg;
   logic          access, misaligned, issue, done, abort;

   assign pc_src        = m_Branch_in & zero_in;
   assign branch_target = add_result_in;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   // Completion (ready or timeout) releases the stall in the same cycle so the
   // upstream latch advances on the edge that writes MEM/WB.
   always_comb begin
      next_state = state;
      access     = m_MemRead_in | m_MemWrite_in;
      misaligned = access & (|alu_result_in[1:0]);
      issue      = 1'b0;
      done       = 1'b0;
      abort      = 1'b0;
      stall      = 1'b0;
      case (state)
         S_IDLE: begin
            issue = access & ~misaligned;
            stall = issue;
            if (issue) next_state = S_WAIT;
         end
         S_WAIT: begin
            done  = mem_ready;
            abort = ~mem_ready & (cnt == CW'(TIMEOUT - 1));
            stall = ~(done | abort);
            if (done | abort) next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt             <= '0;
         mem_req         <= 1'b0;
         mem_we          <= 1'b0;
         mem_addr        <= '0;
         mem_wdata       <= '0;
         cap_dst         <= '0;
         cap_regwrite    <= 1'b0;
         cap_memtoreg    <= 1'b0;
         read_data_out   <= '0;
         alu_result_out  <= '0;
         mux_RegDst_out  <= '0;
         wb_RegWrite_out <= 1'b0;
         wb_MemtoReg_out <= 1'b0;
         mem_error       <= 1'b0;
      end else if (state == S_IDLE) begin
         if (issue) begin
            cnt             <= '0;
            mem_req         <= 1'b1;
            mem_we          <= m_MemWrite_in;
            mem_addr        <= alu_result_in;
            mem_wdata       <= r_data2_in;
            cap_dst         <= mux_RegDst_in;
            cap_regwrite    <= wb_RegWrite_in;
            cap_memtoreg    <= wb_MemtoReg_in;
            wb_RegWrite_out <= 1'b0;
            wb_MemtoReg_out <= 1'b0;
         end else begin
            read_data_out   <= '0;
            alu_result_out  <= alu_result_in;
            mux_RegDst_out  <= mux_RegDst_in;
            wb_RegWrite_out <= wb_RegWrite_in;
            wb_MemtoReg_out <= wb_MemtoReg_in;
            if (misaligned) mem_error <= 1'b1;
         end
      end else begin
         if (done) begin
            mem_req         <= 1'b0;
            read_data_out   <= mem_we ? '0 : mem_rdata;
            alu_result_out  <= mem_addr;
            mux_RegDst_out  <= cap_dst;
            wb_RegWrite_out <= cap_regwrite;
            wb_MemtoReg_out <= cap_memtoreg;
         end else if (abort) begin
            mem_req         <= 1'b0;
            mem_error       <= 1'b1;
            read_data_out   <= '0;
            alu_result_out  <= mem_addr;
            mux_RegDst_out  <= cap_dst;
            wb_RegWrite_out <= 1'b0;
            wb_MemtoReg_out <= cap_memtoreg;
         end else begin
            cnt             <= cnt + 1'b1;
            wb_RegWrite_out <= 1'b0;
            wb_MemtoReg_out <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: expected MEM/WB records are queued when an
// op is driven and compared on the edge where the stage completes it.
module tb_mem_stage_ctrl;

   typedef struct packed {
      logic [31:0] rd;
      logic [31:0] alu;
      logic [4:0]  dst;
      logic        rw;
      logic        mtr;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] add_result_in, alu_result_in, r_data2_in;
   logic [4:0]  mux_RegDst_in;
   logic        zero_in, wb_RegWrite_in, wb_MemtoReg_in;
   logic        m_Branch_in, m_MemRead_in, m_MemWrite_in;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ready, stall, pc_src;
   logic [31:0] branch_target, read_data_out, alu_result_out;
   logic [4:0]  mux_RegDst_out;
   logic        wb_RegWrite_out, wb_MemtoReg_out, mem_error;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   mem_stage_ctrl #(.B(32), .W(5), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset),
      .add_result_in(add_result_in), .alu_result_in(alu_result_in),
      .r_data2_in(r_data2_in), .mux_RegDst_in(mux_RegDst_in), .zero_in(zero_in),
      .wb_RegWrite_in(wb_RegWrite_in), .wb_MemtoReg_in(wb_MemtoReg_in),
      .m_Branch_in(m_Branch_in), .m_MemRead_in(m_MemRead_in), .m_MemWrite_in(m_MemWrite_in),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall), .pc_src(pc_src),
      .branch_target(branch_target), .read_data_out(read_data_out),
      .alu_result_out(alu_result_out), .mux_RegDst_out(mux_RegDst_out),
      .wb_RegWrite_out(wb_RegWrite_out), .wb_MemtoReg_out(wb_MemtoReg_out),
      .mem_error(mem_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_idle();
      add_result_in  = '0;
      alu_result_in  = '0;
      r_data2_in     = '0;
      mux_RegDst_in  = '0;
      zero_in        = 1'b0;
      wb_RegWrite_in = 1'b0;
      wb_MemtoReg_in = 1'b0;
      m_Branch_in    = 1'b0;
      m_MemRead_in   = 1'b0;
      m_MemWrite_in  = 1'b0;
      mem_ready      = 1'b0;
      mem_rdata      = '0;
   endtask

   // n_stall: cycles the stage must hold stall high before completing.
   // give_ready: the memory model answers in the last of those cycles.
   task automatic run_op(input string tag, input logic [31:0] alu, input logic [31:0] wdata,
                         input logic [4:0] dst, input logic rw, input logic mtr,
                         input logic mr, input logic mw, input int unsigned n_stall,
                         input logic give_ready, input logic [31:0] rdata, input exp_t e);
      int unsigned req_cycles = 0;
      exp_t        got;
      @(negedge clk);
      alu_result_in  = alu;
      r_data2_in     = wdata;
      mux_RegDst_in  = dst;
      wb_RegWrite_in = rw;
      wb_MemtoReg_in = mtr;
      m_MemRead_in   = mr;
      m_MemWrite_in  = mw;
      sb.push_back(e);
      for (int unsigned i = 0; i <= n_stall; i++) begin
         if (i > 0) @(negedge clk);
         mem_ready = give_ready && (n_stall > 0) && (i == n_stall);
         mem_rdata = mem_ready ? rdata : $urandom;
         #1;
         check({tag, ".stall"}, 32'(stall), 32'(i < n_stall));
         if (mem_req) req_cycles++;
         if (i == 1) begin
            check({tag, ".we"},    32'(mem_we), 32'(mw));
            check({tag, ".addr"},  mem_addr, alu);
            check({tag, ".wdata"}, mem_wdata, wdata);
         end
         if (i == n_stall && n_stall > 1) begin
            check({tag, ".bubble_rw"},  32'(wb_RegWrite_out), 32'(0));
            check({tag, ".bubble_mtr"}, 32'(wb_MemtoReg_out), 32'(0));
         end
      end
      @(posedge clk);
      #1;
      drive_idle();
      got = '{rd: read_data_out, alu: alu_result_out, dst: mux_RegDst_out,
              rw: wb_RegWrite_out, mtr: wb_MemtoReg_out};
      e = sb.pop_front();
      check({tag, ".read_data"}, got.rd, e.rd);
      check({tag, ".alu_out"},   got.alu, e.alu);
      check({tag, ".dst"},       32'(got.dst), 32'(e.dst));
      check({tag, ".regwrite"},  32'(got.rw), 32'(e.rw));
      check({tag, ".memtoreg"},  32'(got.mtr), 32'(e.mtr));
      check({tag, ".req_cycles"}, req_cycles, n_stall);
      check({tag, ".req_low"},   32'(mem_req), 32'(0));
   endtask

   initial begin
      reset = 1'b1;
      drive_idle();
      #2;
      check("rst.req",  32'(mem_req), 32'(0));
      check("rst.err",  32'(mem_error), 32'(0));
      check("rst.rw",   32'(wb_RegWrite_out), 32'(0));
      check("rst.alu",  alu_result_out, 32'(0));
      check("rst.rd",   read_data_out, 32'(0));
      check("rst.stall", 32'(stall), 32'(0));
      @(negedge clk);
      reset = 1'b0;

      run_op("alu", 32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 32'h0,
             '{rd: 32'h0, alu: 32'h10, dst: 5'd5, rw: 1'b1, mtr: 1'b0});

      @(negedge clk);
      m_Branch_in = 1'b1; zero_in = 1'b1; add_result_in = 32'h100;
      #1;
      check("br.pc_src", 32'(pc_src), 32'(1));
      check("br.target", branch_target, 32'h100);
      check("br.stall",  32'(stall), 32'(0));
      zero_in = 1'b0;
      #1;
      check("br.not_taken", 32'(pc_src), 32'(0));
      drive_idle();

      run_op("load", 32'h40, 32'h0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 4, 1'b1, 32'hDEADBEEF,
             '{rd: 32'hDEADBEEF, alu: 32'h40, dst: 5'd7, rw: 1'b1, mtr: 1'b1});
      run_op("store", 32'h44, 32'h1234, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b1, 32'hCAFEF00D,
             '{rd: 32'h0, alu: 32'h44, dst: 5'd0, rw: 1'b0, mtr: 1'b0});
      check("err.clean", 32'(mem_error), 32'(0));

      run_op("timeout", 32'h80, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 16, 1'b0, 32'h0,
             '{rd: 32'h0, alu: 32'h80, dst: 5'd9, rw: 1'b0, mtr: 1'b1});
      check("timeout.err", 32'(mem_error), 32'(1));

      // Abandon a load mid-WAIT with an asynchronous reset.
      @(negedge clk);
      alu_result_in = 32'h60; mux_RegDst_in = 5'd3;
      wb_RegWrite_in = 1'b1; wb_MemtoReg_in = 1'b1; m_MemRead_in = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst.req_before", 32'(mem_req), 32'(1));
      #2 reset = 1'b1;
      #1;
      check("midrst.req", 32'(mem_req), 32'(0));
      check("midrst.err", 32'(mem_error), 32'(0));
      check("midrst.rw",  32'(wb_RegWrite_out), 32'(0));
      check("midrst.alu", alu_result_out, 32'(0));
      drive_idle();
      @(negedge clk);
      reset = 1'b0;

      run_op("alu2", 32'hABC0, 32'h0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 32'h0,
             '{rd: 32'h0, alu: 32'hABC0, dst: 5'd12, rw: 1'b1, mtr: 1'b0});
      run_op("misalign", 32'h42, 32'h0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 32'h0,
             '{rd: 32'h0, alu: 32'h42, dst: 5'd4, rw: 1'b1, mtr: 1'b1});
      check("misalign.err", 32'(mem_error), 32'(1));
      run_op("both", 32'h48, 32'h55, 5'd6, 1'b0, 1'b0, 1'b1, 1'b1, 2, 1'b1, 32'h87654321,
             '{rd: 32'h0, alu: 32'h48, dst: 5'd6, rw: 1'b0, mtr: 1'b0});
      check("sb.empty", 32'(sb.size()), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
